// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing input PIO: the Avalon word
// addresses of the register map and the width of the address bus.
package pio_pkg;

   localparam int PIO_ADDR_W = 3;

   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA       = 3'd0;
   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_RISE_EN    = 3'd1;
   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQ_MASK   = 3'd2;
   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGE_CAP   = 3'd3;
   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_FALL_EN    = 3'd4;
   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DEB_THRESH = 3'd5;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: a synchroniser chain that brings the asynchronous pin
// into the clk domain, followed by a counter-based debounce filter.  The
// filtered level and a one-cycle update pulse go back to the register file,
// which decides whether the change counts as a rising or a falling edge.
module pio_debounce_ch
   import pio_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             asyncIn,
   input  logic [DEB_W-1:0] thresh,
   output logic             filt,
   output logic             update
);

   logic [SYNC_STAGES-1:0] syncChain;
   logic                   syncBit;
   logic [DEB_W-1:0]       cnt;

   // Shift the raw pin through SYNC_STAGES flops so the debounce logic only
   // ever sees a settled value; the oldest stage is the synchronised level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncChain <= '0;
      end else begin
         syncChain <= {syncChain[SYNC_STAGES-2:0], asyncIn};
      end
   end

   assign syncBit = syncChain[SYNC_STAGES-1];

   // Debounce filter: count consecutive cycles where the synchronised level
   // disagrees with the accepted level.  Once the count has reached the
   // threshold the new level is accepted and a single update pulse is
   // raised alongside it.  Any agreeing cycle throws the count away, so a
   // short glitch never gets through.  The count saturates instead of
   // wrapping so a huge threshold cannot be skipped past.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt   <= 1'b0;
         cnt    <= '0;
         update <= 1'b0;
      end else begin
         update <= 1'b0;
         if (syncBit == filt) begin
            cnt <= '0;
         end else if (cnt >= thresh) begin
            filt   <= syncBit;
            cnt    <= '0;
            update <= 1'b1;
         end else if (cnt != {DEB_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pio_edge_irq_in.sv
// Edge-capturing, debounced input PIO with a masked level interrupt, sitting
// on Avalon-MM as a slave with a fixed read latency of one cycle.  Each of
// the WIDTH channels is filtered by its own pio_debounce_ch; this level holds
// the shared register file, the sticky edge-capture bits, the read mux and
// the interrupt.
module pio_edge_irq_in
   import pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 16,
   parameter int DEB_RESET   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PIO_ADDR_W-1:0] address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [WIDTH-1:0]      in_port,
   output logic                  irq
);

   logic [WIDTH-1:0] filtVec;
   logic [WIDTH-1:0] updVec;
   logic [WIDTH-1:0] riseEn;
   logic [WIDTH-1:0] fallEn;
   logic [WIDTH-1:0] irqMask;
   logic [WIDTH-1:0] edgeCap;
   logic [DEB_W-1:0] debThresh;
   logic [WIDTH-1:0] riseEv;
   logic [WIDTH-1:0] fallEv;
   logic [WIDTH-1:0] capClear;
   logic [31:0]      readMux;
   logic             wrStrobe;
   logic             unusedWriteData;

   assign wrStrobe        = chipselect & ~write_n;
   assign unusedWriteData = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : gChan
      pio_debounce_ch #(
         .SYNC_STAGES(SYNC_STAGES),
         .DEB_W      (DEB_W)
      ) uDeb (
         .clk    (clk),
         .reset  (reset),
         .asyncIn(in_port[i]),
         .thresh (debThresh),
         .filt   (filtVec[i]),
         .update (updVec[i])
      );
   end

   // The update pulse arrives together with the new filtered level, so the
   // level itself tells us which direction the channel just moved.
   assign riseEv   = updVec & filtVec & riseEn;
   assign fallEv   = updVec & ~filtVec & fallEn;
   assign capClear = (wrStrobe && address == PIO_ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

   // Plain read/write configuration registers.  Rising edges are enabled on
   // every channel out of reset so the block behaves like its single-bit
   // predecessor without any setup.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         riseEn    <= '1;
         irqMask   <= '0;
         fallEn    <= '0;
         debThresh <= DEB_W'(DEB_RESET);
      end else if (wrStrobe) begin
         case (address)
            PIO_ADDR_RISE_EN:    riseEn    <= writedata[WIDTH-1:0];
            PIO_ADDR_IRQ_MASK:   irqMask   <= writedata[WIDTH-1:0];
            PIO_ADDR_FALL_EN:    fallEn    <= writedata[WIDTH-1:0];
            PIO_ADDR_DEB_THRESH: debThresh <= writedata[DEB_W-1:0];
            default: ;
         endcase
      end
   end

   // Sticky edge capture.  Software clears bits by writing ones; an edge
   // that lands on the same cycle as its clear is OR-ed in afterwards, so the
   // fresh event is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edgeCap <= '0;
      end else begin
         edgeCap <= (edgeCap & ~capClear) | riseEv | fallEv;
      end
   end

   // Address decode for reads.  Unused upper bits and unmapped addresses
   // read back as zero.
   always_comb begin
      readMux = '0;
      case (address)
         PIO_ADDR_DATA:       readMux[WIDTH-1:0] = filtVec;
         PIO_ADDR_RISE_EN:    readMux[WIDTH-1:0] = riseEn;
         PIO_ADDR_IRQ_MASK:   readMux[WIDTH-1:0] = irqMask;
         PIO_ADDR_EDGE_CAP:   readMux[WIDTH-1:0] = edgeCap;
         PIO_ADDR_FALL_EN:    readMux[WIDTH-1:0] = fallEn;
         PIO_ADDR_DEB_THRESH: readMux[DEB_W-1:0] = debThresh;
         default: ;
      endcase
   end

   // Register the read mux every cycle regardless of chipselect, which is
   // what gives the bus its fixed one-cycle read latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         readdata <= readMux;
      end
   end

   assign irq = |(edgeCap & irqMask);

endmodule
